proc_param: RTL

- Parametrised next-generation multi-cycle processor datapath and controller for the lab processor family.
- Register count and data width are configurable, and the instruction set grows to eight opcodes: logic, shift, and a conditional move on a zero flag.
- Runs a Run/Done handshake and a single shared internal bus, a register file, an A/G accumulator pair and a T0–T3 step FSM.
- Sits between an instruction/data source on DIN (counter-driven ROM in the lab top) and the board display on BusWires.

---
 rtl/proc_param_if.sv | 23 ++
 rtl/proc_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/proc_param_if.sv
// Processor handshake and display bus: Run/DIN in from the instruction
// source, Done/BusWires/Zflag out to the lab top and board display.
interface proc_param_if #(
   parameter int N = 16
);
   logic         Run;
   logic [N-1:0] DIN;
   logic         Done;
   logic [N-1:0] BusWires;
   logic         Zflag;

   // Instruction/data source side
   modport master (
      output Run, DIN,
      input  Done, BusWires, Zflag
   );

   // Processor side
   modport slave (
      input  Run, DIN,
      output Done, BusWires, Zflag
   );
endinterface

// File: rtl/proc_param.sv
// Parametrised multi-cycle lab processor: one shared bus, 2**RB registers,
// A/G accumulator pair, zero flag and a T0..T3 step controller.
// Instruction format (DIN[IW-1:0] in T0): III XX..X YY..Y.
module proc_param #(
   parameter int N  = 16,
   parameter int RB = 3
) (
   input  logic        Clock,
   input  logic        Reset,
   proc_param_if.slave bus_if
);
   localparam int IW = 3 + 2*RB;
   localparam int NR = 2**RB;
   localparam int SW = $clog2(N);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {T0, T1, T2, T3} step_e;
   typedef enum logic [2:0] {
      OP_MV   = 3'b000,
      OP_MVI  = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_AND  = 3'b100,
      OP_XOR  = 3'b101,
      OP_MVNZ = 3'b110,
      OP_SLL  = 3'b111
   } op_e;
   typedef enum logic [1:0] {SRC_NONE, SRC_REG, SRC_G, SRC_DIN} src_e;

   // Architectural state
   step_e                step_q;
   logic [IW-1:0]        ir_q;
   logic [N-1:0]         a_q;
   logic [N-1:0]         g_q;
   logic                 z_q;
   logic [NR-1:0][N-1:0] r_q;

   // Decode and control
   op_e           op;
   logic [RB-1:0] rx, ry, rsel;
   src_e          src;
   logic          rin, ain, gin, done, is_alu;
   logic [N-1:0]  bus, alu;

   assign op     = op_e'(ir_q[IW-1 -: 3]);
   assign rx     = ir_q[2*RB-1 -: RB];
   assign ry     = ir_q[RB-1:0];
   // mv, mvi and mvnz finish in T1; everything else uses the A/G path
   assign is_alu = !(op inside {OP_MV, OP_MVI, OP_MVNZ});

   // Per-step control: bus source, register enables and Done
   always_comb begin
      src  = SRC_NONE;
      rsel = ry;
      rin  = 1'b0;
      ain  = 1'b0;
      gin  = 1'b0;
      done = 1'b0;
      case (step_q)
         T1: begin
            case (op)
               OP_MV: begin
                  src  = SRC_REG;
                  rin  = 1'b1;
                  done = 1'b1;
               end
               OP_MVI: begin
                  src  = SRC_DIN;
                  rin  = 1'b1;
                  done = 1'b1;
               end
               OP_MVNZ: begin
                  // Move is suppressed when Z is set, but the instruction still ends
                  src  = SRC_REG;
                  rin  = !z_q;
                  done = 1'b1;
               end
               default: begin
                  src  = SRC_REG;
                  rsel = rx;
                  ain  = 1'b1;
               end
            endcase
         end
         T2: begin
            if (is_alu) begin
               src = SRC_REG;
               gin = 1'b1;
            end
         end
         T3: begin
            if (is_alu) begin
               src  = SRC_G;
               rin  = 1'b1;
               done = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Shared bus mux; idles at zero when nothing drives it
   always_comb begin
      bus = '0;
      case (src)
         SRC_REG: bus = r_q[rsel];
         SRC_G:   bus = g_q;
         SRC_DIN: bus = bus_if.DIN;
         default: ;
      endcase
   end

   // ALU: A op bus, modulo 2**N; shift amount is the low log2(N) bus bits
   always_comb begin
      case (op)
         OP_ADD:  alu = a_q + bus;
         OP_SUB:  alu = a_q + ~bus + ONE;
         OP_AND:  alu = a_q & bus;
         OP_XOR:  alu = a_q ^ bus;
         OP_SLL:  alu = a_q << bus[SW-1:0];
         default: alu = bus;
      endcase
   end

   // Step controller and instruction register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         step_q <= T0;
         ir_q   <= '0;
      end else begin
         case (step_q)
            T0: begin
               if (bus_if.Run) begin
                  ir_q   <= bus_if.DIN[IW-1:0];
                  step_q <= T1;
               end
            end
            T1:      step_q <= done ? T0 : T2;
            T2:      step_q <= T3;
            default: step_q <= T0;
         endcase
      end
   end

   // Datapath registers: A, G/Z and the register file (only rX is ever written)
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         a_q <= '0;
         g_q <= '0;
         z_q <= 1'b0;
         r_q <= '0;
      end else begin
         if (ain) a_q <= bus;
         if (gin) begin
            g_q <= alu;
            z_q <= (alu == '0);
         end
         if (rin) r_q[rx] <= bus;
      end
   end

   assign bus_if.Done     = done;
   assign bus_if.BusWires = bus;
   assign bus_if.Zflag    = z_q;
endmodule
